// File: rtl/kij_seq_pkg.sv
// Shared types and constants for the kij layer sequencer.
// The KIJ_SEQ_OFIFO_STALL_EN macro (used in kij_sequencer) enables OFIFO back-pressure in OFRD.
package kij_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_RST, S_KL0, S_KLOAD, S_GAP, S_XL0, S_EXEC, S_OFRD, S_DRAIN
    } state_e;

    // Instruction word bit positions
    localparam int I_ACC      = 33;
    localparam int I_CEN_P    = 32;
    localparam int I_WEN_P    = 31;
    localparam int I_AP_LO    = 20;
    localparam int I_CEN_X    = 19;
    localparam int I_WEN_X    = 18;
    localparam int I_AX_LO    = 7;
    localparam int I_OFIFO_RD = 6;
    localparam int I_IFIFO_WR = 5;
    localparam int I_IFIFO_RD = 4;
    localparam int I_L0_RD    = 3;
    localparam int I_L0_WR    = 2;
    localparam int I_EXEC     = 1;
    localparam int I_LOAD     = 0;

    localparam int ADDR_W     = 11;
    localparam int TW         = 16;

    localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;

    localparam int RST_CYC    = 11;
    localparam int RST_ON_CYC = 10;
    localparam int GAP_CYC    = 11;
    localparam int DRAIN_CYC  = 3;
    localparam int KIJ_LAST   = 8;

endpackage

// File: rtl/kij_addr_gen.sv
// Address generation: kernel word address in xmem and shifted psum address in pmem.
module kij_addr_gen
    import kij_seq_pkg::*;
#(
    parameter int              nij_sz = 6,
    parameter logic [10:0]     wbase  = 11'h400
) (
    input  logic [3:0]         kij,
    input  logic [ADDR_W-1:0]  t,
    input  logic [ADDR_W-1:0]  klen,
    output logic [ADDR_W-1:0]  a_kern,
    output logic [ADDR_W-1:0]  a_pmem
);

    logic [3:0] kmod;
    logic [3:0] kdiv;

    assign kmod = kij % 4'd3;
    assign kdiv = kij / 4'd3;

    assign a_kern = wbase + ADDR_W'(kij * klen) + t;

    // Output pixel offset for kernel tap (kij%3, kij/3); negative results wrap mod 2^11.
    assign a_pmem = t - ADDR_W'(1) - ADDR_W'(kmod) - ADDR_W'(32'(kdiv) * nij_sz);

endmodule

// File: rtl/kij_sequencer.sv
// Sequences the 9 kernel taps of a layer through the core, one instruction word per cycle.
// Define KIJ_SEQ_OFIFO_STALL_EN to make OFRD pmem writes wait on ofifo_valid.
module kij_sequencer
    import kij_seq_pkg::*;
#(
    parameter int          row     = 8,
    parameter int          col     = 8,
    parameter int          len_nij = 36,
    parameter int          nij_sz  = 6,
    parameter logic [10:0] wbase   = 11'h400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode_in,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        mode,
    output logic        sel,
    output logic        core_rst,
    output logic        busy,
    output logic        done
);

    state_e          state_q, state_d;
    logic [TW-1:0]   t_q, t_d;
    logic [3:0]      kij_q, kij_d;
    logic            mode_lat_q, mode_lat_d;
    logic [33:0]     inst_q, inst_d;
    logic            mode_q, mode_d;
    logic            sel_q, sel_d;
    logic            core_rst_q, core_rst_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            wr_d;

    logic [TW-1:0]     klen;
    logic [ADDR_W-1:0] a_kern, a_pmem;

    assign klen = mode_lat_d ? TW'(col) : TW'(2 * col);

    // Addresses are derived from the next-cycle counters so they land with the registered word.
    kij_addr_gen #(.nij_sz(nij_sz), .wbase(wbase)) u_addr (
        .kij    (kij_d),
        .t      (t_d[ADDR_W-1:0]),
        .klen   (klen[ADDR_W-1:0]),
        .a_kern (a_kern),
        .a_pmem (a_pmem)
    );

`ifndef KIJ_SEQ_OFIFO_STALL_EN
    logic unused_ofifo_valid;
    assign unused_ofifo_valid = ofifo_valid;
`endif

    always_comb begin
        state_d    = state_q;
        t_d        = t_q + TW'(1);
        kij_d      = kij_q;
        mode_lat_d = mode_lat_q;
        done_d     = 1'b0;
        wr_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                t_d = '0;
                if (start) begin
                    state_d    = S_RST;
                    kij_d      = '0;
                    mode_lat_d = mode_in;
                end
            end
            S_RST:   if (t_q == TW'(RST_CYC - 1))        begin state_d = S_KL0;   t_d = '0; end
            S_KL0:   if (t_q == klen - TW'(1))           begin state_d = S_KLOAD; t_d = '0; end
            S_KLOAD: if (t_q == TW'(row) + klen - TW'(1)) begin state_d = S_GAP;   t_d = '0; end
            S_GAP:   if (t_q == TW'(GAP_CYC - 1))        begin state_d = S_XL0;   t_d = '0; end
            S_XL0:   if (t_q == TW'(len_nij - 1))        begin state_d = S_EXEC;  t_d = '0; end
            S_EXEC:  if (t_q == TW'(len_nij) + klen - TW'(1)) begin state_d = S_OFRD; t_d = '0; end
            S_OFRD: begin
`ifdef KIJ_SEQ_OFIFO_STALL_EN
                if (t_q == TW'(len_nij)) begin
                    state_d = S_DRAIN;
                    t_d     = '0;
                end else if (ofifo_valid) begin
                    wr_d = 1'b1;
                end else begin
                    t_d = t_q;
                end
`else
                if (t_q == TW'(len_nij)) begin
                    state_d = S_DRAIN;
                    t_d     = '0;
                end else begin
                    wr_d = 1'b1;
                end
`endif
            end
            S_DRAIN: begin
                if (t_q == TW'(DRAIN_CYC - 1)) begin
                    t_d = '0;
                    if (kij_q == 4'(KIJ_LAST)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RST;
                        kij_d   = kij_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                t_d     = '0;
            end
        endcase
    end

    // Output word for the cycle that state_d/t_d describe.
    always_comb begin
        inst_d     = INST_IDLE;
        core_rst_d = 1'b0;
        sel_d      = sel_q;
        case (state_d)
            S_RST: core_rst_d = (t_d < TW'(RST_ON_CYC));
            S_KL0: begin
                inst_d[I_CEN_X]             = 1'b0;
                inst_d[I_L0_WR]             = 1'b1;
                inst_d[I_AX_LO +: ADDR_W]   = a_kern;
            end
            S_KLOAD: begin
                inst_d[I_L0_RD] = 1'b1;
                inst_d[I_LOAD]  = (t_d < klen);
            end
            S_XL0: begin
                inst_d[I_CEN_X]           = 1'b0;
                inst_d[I_L0_WR]           = 1'b1;
                inst_d[I_AX_LO +: ADDR_W] = t_d[ADDR_W-1:0];
            end
            S_EXEC: begin
                inst_d[I_L0_RD] = 1'b1;
                inst_d[I_EXEC]  = (t_d < TW'(len_nij));
            end
            S_OFRD: begin
                inst_d[I_ACC] = (kij_d != 4'd0);
                if (state_q != S_OFRD) sel_d = kij_d[0];
                if (t_d != '0) inst_d[I_AP_LO +: ADDR_W] = a_pmem;
                if (wr_d) begin
                    inst_d[I_CEN_P] = 1'b0;
                    inst_d[I_WEN_P] = 1'b0;
                end
`ifdef KIJ_SEQ_OFIFO_STALL_EN
                inst_d[I_OFIFO_RD] = wr_d || (state_q != S_OFRD);
`else
                inst_d[I_OFIFO_RD] = 1'b1;
`endif
            end
            S_DRAIN: inst_d[I_ACC] = (kij_d != 4'd0) && (t_d <= TW'(1));
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
        mode_d = busy_d & mode_lat_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            t_q        <= '0;
            kij_q      <= '0;
            mode_lat_q <= 1'b0;
            inst_q     <= INST_IDLE;
            mode_q     <= 1'b0;
            sel_q      <= 1'b0;
            core_rst_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            kij_q      <= kij_d;
            mode_lat_q <= mode_lat_d;
            inst_q     <= inst_d;
            mode_q     <= mode_d;
            sel_q      <= sel_d;
            core_rst_q <= core_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign inst     = inst_q;
    assign mode     = mode_q;
    assign sel      = sel_q;
    assign core_rst = core_rst_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_kij_sequencer.sv
// Scoreboard bench: a per-pass expected trace is built from the phase rules and checked cycle by cycle.
module tb_kij_sequencer;

    localparam int          ROW = 8, COL = 8, LEN = 36, NSZ = 6;
    localparam logic [10:0] WB  = 11'h400;
    localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, mode_in = 1'b0, ofifo_valid = 1'b1;
    logic [33:0] inst;
    logic        mode, sel, core_rst, busy, done;

    kij_sequencer #(.row(ROW), .col(COL), .len_nij(LEN), .nij_sz(NSZ), .wbase(WB)) dut (
        .clk(clk), .reset(reset), .start(start), .mode_in(mode_in), .ofifo_valid(ofifo_valid),
        .inst(inst), .mode(mode), .sel(sel), .core_rst(core_rst), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [33:0] inst;
        logic        core_rst, busy, mode, sel, done;
        int          kij;
        string       ph;
        int          t;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0, n_bad = 0;
    int   cyc = 0, pass_start = 0, exp_len = 0;
    logic sel_m = 1'b0;

    task automatic push(input logic [33:0] iw, input logic cr, input logic bz, input logic md,
                        input logic dn, input int kij, input string ph, input int t);
        exp_t e;
        e.inst = iw; e.core_rst = cr; e.busy = bz; e.mode = md; e.sel = sel_m; e.done = dn;
        e.kij = kij; e.ph = ph; e.t = t;
        exp_q.push_back(e);
    endtask

    // Expected trace of one full 9-tap pass, first RST cycle through the done cycle.
    task automatic gen_pass(input logic md, input int stall_at);
        int klen = md ? COL : 2 * COL;
        int n = 0;
        logic [33:0] iw;
        for (int kij = 0; kij < 9; kij++) begin
            int off = kij % 3 + (kij / 3) * NSZ;
            for (int c = 0; c < 11; c++) begin push(IDLE_W, c < 10, 1, md, 0, kij, "RST", c); n++; end
            for (int c = 0; c < klen; c++) begin
                iw = IDLE_W; iw[19] = 0; iw[2] = 1; iw[17:7] = 11'(WB + kij * klen + c);
                push(iw, 0, 1, md, 0, kij, "KL0", c); n++;
            end
            for (int c = 0; c < ROW + klen; c++) begin
                iw = IDLE_W; iw[3] = 1; iw[0] = (c < klen);
                push(iw, 0, 1, md, 0, kij, "KLOAD", c); n++;
            end
            for (int c = 0; c < 11; c++) begin push(IDLE_W, 0, 1, md, 0, kij, "GAP", c); n++; end
            for (int c = 0; c < LEN; c++) begin
                iw = IDLE_W; iw[19] = 0; iw[2] = 1; iw[17:7] = 11'(c);
                push(iw, 0, 1, md, 0, kij, "XL0", c); n++;
            end
            for (int c = 0; c < LEN + klen; c++) begin
                iw = IDLE_W; iw[3] = 1; iw[1] = (c < LEN);
                push(iw, 0, 1, md, 0, kij, "EXEC", c); n++;
            end
            sel_m = 1'(kij & 1);
            for (int c = 0; c <= LEN; c++) begin
                iw = IDLE_W; iw[33] = (kij > 0); iw[6] = 1;
                if (c >= 1) begin iw[30:20] = 11'(c - 1 - off); iw[32] = 0; iw[31] = 0; end
                push(iw, 0, 1, md, 0, kij, "OFRD", c); n++;
`ifdef KIJ_SEQ_OFIFO_STALL_EN
                if (kij == 0 && c == stall_at) begin
                    iw[32] = 1; iw[31] = 1; iw[6] = 0;
                    for (int s = 0; s < 5; s++) begin push(iw, 0, 1, md, 0, kij, "OFRD_STALL", c); n++; end
                end
`endif
            end
            for (int c = 0; c < 3; c++) begin
                iw = IDLE_W; iw[33] = (kij > 0) && (c <= 1);
                push(iw, 0, 1, md, 0, kij, "DRAIN", c); n++;
            end
        end
        push(IDLE_W, 0, 0, 0, 1, 8, "DONE", 0);
        exp_len = n;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        cyc++;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else begin
            e.inst = IDLE_W; e.core_rst = 0; e.busy = 0; e.mode = 0; e.sel = sel_m; e.done = 0;
            e.kij = -1; e.ph = "IDLE"; e.t = 0;
        end
        n_cmp++;
        if ({inst, core_rst, busy, mode, sel, done} !== {e.inst, e.core_rst, e.busy, e.mode, e.sel, e.done}) begin
            n_bad++;
            $display("FAIL %s kij=%0d t=%0d: got inst=%h rst=%b busy=%b mode=%b sel=%b done=%b, want inst=%h rst=%b busy=%b mode=%b sel=%b done=%b",
                     e.ph, e.kij, e.t, inst, core_rst, busy, mode, sel, done,
                     e.inst, e.core_rst, e.busy, e.mode, e.sel, e.done);
        end
        if (done === 1'b1) begin
            n_cmp++;
            if (cyc - pass_start - 1 != exp_len) begin
                n_bad++;
                $display("FAIL pass_len: got %0d cycles, want %0d", cyc - pass_start - 1, exp_len);
            end
        end
    end

    // One pass; stall_at >= 0 drops ofifo_valid for 5 edges after kij0 OFRD write t=stall_at.
    task automatic run_pass(input logic md, input int stall_at, input bit spur, input bit end_start);
        int klen = md ? COL : 2 * COL;
        int ofs  = 11 + 3 * klen + ROW + 11 + 2 * LEN;
        @(posedge clk); #1 start = 1; mode_in = md;
        @(posedge clk);
        gen_pass(md, stall_at);
        pass_start = cyc;
        #1;
        for (int k = 1; k <= exp_len; k++) begin
            mode_in     = 1'($urandom_range(0, 1));
            start       = (k == exp_len) ? end_start : 1'(spur && ($urandom_range(0, 19) == 0));
            ofifo_valid = !(stall_at >= 0 && k >= ofs + stall_at + 1 && k <= ofs + stall_at + 5);
            @(posedge clk); #1;
        end
        start = 0; ofifo_valid = 1;
    endtask

    task automatic run_reset(input logic md);
        int klen = md ? COL : 2 * COL;
        int ofs_exec = 11 + 3 * klen + ROW + 11 + LEN;
        @(posedge clk); #1 start = 1; mode_in = md;
        @(posedge clk);
        gen_pass(md, -1);
        pass_start = cyc;
        #1 start = 0;
        repeat (ofs_exec + 5) @(posedge clk);
        #1 reset = 1;
        @(posedge clk);
        exp_q.delete();
        sel_m = 1'b0;
        #1 reset = 0;
        repeat (20) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 0;
        repeat (4) @(posedge clk);
        run_pass(1'b0, 10, 1'b1, 1'b1);
        repeat (5 + $urandom_range(0, 10)) @(posedge clk);
        run_pass(1'b1, -1, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        run_reset(1'($urandom_range(0, 1)));
        run_pass(1'($urandom_range(0, 1)), int'($urandom_range(1, 30)), 1'b1, 1'b0);
        for (int i = 0; i < 5000 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: got %0d entries left, want 0", exp_q.size());
        end
        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
